// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: shared serial bus arbiter with fixed-priority / round-robin
// selection and grant-acceptance / bus-hold watchdogs.
//
// One owner at a time holds a registered one-hot grant. Ownership ends when
// the owner finishes (bus_util and slave-busy both low), abandons its request
// before using the bus, or trips a watchdog. Every ownership ends with a
// single RELEASE cycle with grants low, so two owners never overlap.
module bus_arbiter_rr #(
  parameter int N_MASTERS    = 12,
  parameter int N_SLAVES     = 6,
  parameter int MID_W        = 4,
  parameter int ACK_TIMEOUT  = 15,
  parameter int HOLD_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] m_reqs,
  input  logic [N_SLAVES-1:0]  slaves,
  input  logic                 bus_util,
  input  logic                 rr_mode,
  output logic [N_MASTERS-1:0] m_grants,
  output logic [MID_W-1:0]     mid_current,
  output logic [2:0]           state,
  output logic                 timeout_evt
);

  // Watchdog counter widths are fixed by the bus timing budget.
  localparam int ACK_W  = 4;
  localparam int HOLD_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_BUSY    = 3'd2,
    ST_RELEASE = 3'd3
  } state_t;

  state_t                state_q, state_d;
  logic [N_MASTERS-1:0]  grants_q, grants_d;
  logic [MID_W-1:0]      mid_q, mid_d;
  logic [MID_W-1:0]      ptr_q, ptr_d;
  logic [ACK_W-1:0]      ack_cnt_q, ack_cnt_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                  evt_q, evt_d;

  logic                  slave_busy;
  logic                  owner_req;
  logic [MID_W-1:0]      fixed_winner;
  logic [MID_W-1:0]      rr_winner;
  logic [MID_W-1:0]      winner;

  // Doubled request vector lets a single shift rotate the requests so that
  // bit 0 of the rotated view is the master just after the pointer.
  logic [2*N_MASTERS-1:0] req_dbl;
  logic [2*N_MASTERS-1:0] req_shifted;
  logic [N_MASTERS-1:0]   req_rot;
  logic [MID_W:0]         rr_shamt;
  logic [MID_W-1:0]       rr_offset;
  logic [MID_W:0]         rr_sum;

  assign slave_busy = |slaves;
  // The owner is still interested if its own request line is high.
  assign owner_req  = |(m_reqs & grants_q);

  // Fixed priority: lowest set request index wins.
  always_comb begin
    fixed_winner = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (m_reqs[i]) fixed_winner = MID_W'(i);
    end
  end

  // Round robin: first set request scanning upward from ptr+1, wrapping.
  always_comb begin
    req_dbl     = {m_reqs, m_reqs};
    rr_shamt    = {1'b0, ptr_q} + (MID_W+1)'(1);
    req_shifted = req_dbl >> rr_shamt;
    req_rot     = req_shifted[N_MASTERS-1:0];
    rr_offset   = '0;
    for (int j = N_MASTERS - 1; j >= 0; j--) begin
      if (req_rot[j]) rr_offset = MID_W'(j);
    end
    rr_sum = rr_shamt + {1'b0, rr_offset};
    if (rr_sum >= (MID_W+1)'(N_MASTERS)) rr_sum = rr_sum - (MID_W+1)'(N_MASTERS);
    rr_winner = rr_sum[MID_W-1:0];
  end

  // rr_mode only matters here, and this result is only consumed in IDLE.
  assign winner = rr_mode ? rr_winner : fixed_winner;

  // Next-state, next-grant and watchdog logic.
  always_comb begin
    // NOTE: every signal assigned below gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    grants_d   = grants_q;
    mid_d      = mid_q;
    ptr_d      = ptr_q;
    ack_cnt_d  = ack_cnt_q;
    hold_cnt_d = hold_cnt_q;
    evt_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        grants_d   = '0;
        ack_cnt_d  = '0;
        hold_cnt_d = '0;
        if (|m_reqs) begin
          state_d  = ST_GRANT;
          grants_d = {{(N_MASTERS-1){1'b0}}, 1'b1} << winner;
          mid_d    = winner;
          ptr_d    = winner;
        end
      end

      ST_GRANT: begin
        if (bus_util) begin
          state_d   = ST_BUSY;
          ack_cnt_d = '0;
        end else if (!owner_req) begin
          // Master dropped its request before ever driving the bus.
          state_d  = ST_RELEASE;
          grants_d = '0;
        end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          // Granted master never answered: reclaim the bus.
          state_d  = ST_RELEASE;
          grants_d = '0;
          evt_d    = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end

      ST_BUSY: begin
        if (!bus_util && !slave_busy) begin
          state_d  = ST_RELEASE;
          grants_d = '0;
        end else if (hold_cnt_q == HOLD_W'(HOLD_TIMEOUT - 1)) begin
          // Owner or a slave is stuck: force the bus free.
          state_d  = ST_RELEASE;
          grants_d = '0;
          evt_d    = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_RELEASE: begin
        state_d    = ST_IDLE;
        grants_d   = '0;
        ack_cnt_d  = '0;
        hold_cnt_d = '0;
      end

      default: begin
        state_d  = ST_IDLE;
        grants_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      grants_q   <= '0;
      mid_q      <= '0;
      ptr_q      <= MID_W'(N_MASTERS - 1);
      ack_cnt_q  <= '0;
      hold_cnt_q <= '0;
      evt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grants_q   <= grants_d;
      mid_q      <= mid_d;
      ptr_q      <= ptr_d;
      ack_cnt_q  <= ack_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      evt_q      <= evt_d;
    end
  end

  assign m_grants    = grants_q;
  assign mid_current = mid_q;
  assign state       = state_q;
  assign timeout_evt = evt_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios followed by a
// randomized run, all compared every cycle against a behavioural model.
module tb_bus_arbiter_rr;

  localparam int N       = 12;
  localparam int NS      = 6;
  localparam int MW      = 4;
  localparam int ACK_TO  = 15;
  localparam int HOLD_TO = 1023;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  m_reqs;
  logic [NS-1:0] slaves;
  logic          bus_util;
  logic          rr_mode;
  logic [N-1:0]  m_grants;
  logic [MW-1:0] mid_current;
  logic [2:0]    state;
  logic          timeout_evt;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: phase 0 idle, 1 granted, 2 in use, 3 release.
  int           md_phase  = 0;
  int           md_mid    = 0;
  int           md_ptr    = N - 1;
  int           md_wait   = 0;
  logic [N-1:0] md_grants = '0;
  logic         md_evt    = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(
    .N_MASTERS(N), .N_SLAVES(NS), .MID_W(MW),
    .ACK_TIMEOUT(ACK_TO), .HOLD_TIMEOUT(HOLD_TO)
  ) dut (
    .clk(clk), .rst(rst), .m_reqs(m_reqs), .slaves(slaves),
    .bus_util(bus_util), .rr_mode(rr_mode), .m_grants(m_grants),
    .mid_current(mid_current), .state(state), .timeout_evt(timeout_evt)
  );

  function automatic int pick_winner(logic [N-1:0] r, logic rr, int p);
    if (!rr) begin
      for (int i = 0; i < N; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int w;
    md_evt = 1'b0;
    if (rst) begin
      md_phase = 0; md_mid = 0; md_ptr = N - 1; md_wait = 0; md_grants = '0;
    end else begin
      case (md_phase)
        0: begin
          md_grants = '0;
          if (m_reqs != 0) begin
            w = pick_winner(m_reqs, rr_mode, md_ptr);
            md_phase = 1; md_mid = w; md_ptr = w; md_wait = 0;
            md_grants = '0;
            md_grants[w] = 1'b1;
          end
        end
        1: begin
          md_wait++;
          if (bus_util) begin
            md_phase = 2; md_wait = 0;
          end else if (!m_reqs[md_mid]) begin
            md_phase = 3; md_grants = '0;
          end else if (md_wait >= ACK_TO) begin
            md_phase = 3; md_grants = '0; md_evt = 1'b1;
          end
        end
        2: begin
          md_wait++;
          if (!bus_util && slaves == 0) begin
            md_phase = 3; md_grants = '0;
          end else if (md_wait >= HOLD_TO) begin
            md_phase = 3; md_grants = '0; md_evt = 1'b1;
          end
        end
        default: begin
          md_phase = 0; md_wait = 0; md_grants = '0;
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("grants", 32'(m_grants), 32'(md_grants));
    check("mid", 32'(mid_current), 32'(md_mid));
    check("state", 32'(state), 32'(md_phase));
    check("evt", 32'(timeout_evt), 32'(md_evt));
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 30 && m_grants == 0; i++) tick();
    check("grant_seen", 32'(m_grants != 0), 32'd1);
  endtask

  // Serve one ownership: expect a given grant, drive bus_util for `hold`
  // cycles, then measure the dead time until the next grant appears.
  task automatic serve(input logic [N-1:0] exp_grant, input int hold);
    int gap;
    wait_grant();
    check("grant_seq", 32'(m_grants), 32'(exp_grant));
    bus_util = 1'b1;
    repeat (hold) tick();
    bus_util = 1'b0;
    gap = 0;
    do begin
      tick();
      gap++;
    end while (m_grants == 0 && gap < 20);
    check("handover_gap", gap, 32'd3);
  endtask

  initial begin
    int n;
    rst = 1'b1; m_reqs = 12'hFFF; slaves = '0; bus_util = 1'b0; rr_mode = 1'b0;

    // Reset held with every master requesting.
    repeat (2) tick();
    check("rst_grants", 32'(m_grants), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_mid", 32'(mid_current), 32'd0);
    check("rst_evt", 32'(timeout_evt), 32'd0);
    rst = 1'b0;
    tick();
    check("first_grant", 32'(m_grants), 32'h001);
    m_reqs = '0;
    repeat (3) tick();

    // Fixed priority: master 2 keeps winning.
    rr_mode = 1'b0; m_reqs = 12'h034;
    repeat (3) serve(12'h004, 3);

    // Round robin from a fresh pointer.
    rst = 1'b1; tick(); rst = 1'b0;
    rr_mode = 1'b1;
    serve(12'h004, 3);
    serve(12'h010, 3);
    serve(12'h020, 3);
    serve(12'h004, 3);
    m_reqs = '0;
    repeat (3) tick();

    // Grant-acceptance watchdog.
    m_reqs = 12'h020;
    wait_grant();
    n = 0;
    do begin tick(); n++; end while (!timeout_evt && n < 40);
    check("ack_to_cycles", n, 32'd15);
    check("ack_to_mid", 32'(mid_current), 32'd5);
    check("ack_to_grants", 32'(m_grants), 32'd0);
    tick();
    check("ack_to_idle", 32'(state), 32'd0);
    tick();
    check("ack_to_regrant", 32'(m_grants), 32'h020);
    m_reqs = '0;
    repeat (3) tick();

    // Slave-busy extends ownership after bus_util falls.
    m_reqs = 12'h008;
    wait_grant();
    bus_util = 1'b1; tick();
    slaves = 6'h08; bus_util = 1'b0;
    repeat (5) begin
      tick();
      check("slave_hold", 32'(state), 32'd2);
    end
    slaves = '0; tick();
    check("slave_release", 32'(state), 32'd3);
    m_reqs = '0;
    repeat (2) tick();

    // Bus-hold watchdog with bus_util stuck high.
    m_reqs = 12'h002;
    wait_grant();
    bus_util = 1'b1; tick();
    n = 0;
    do begin tick(); n++; end while (!timeout_evt && n < 1100);
    check("hold_to_cycles", n, 32'd1023);
    check("hold_to_grants", 32'(m_grants), 32'd0);
    bus_util = 1'b0; m_reqs = '0;
    repeat (3) tick();

    // Reset while master 4 owns the bus.
    m_reqs = 12'h010;
    wait_grant();
    bus_util = 1'b1;
    repeat (3) tick();
    check("pre_rst_state", 32'(state), 32'd2);
    rst = 1'b1; tick();
    check("mid_rst_grants", 32'(m_grants), 32'd0);
    check("mid_rst_state", 32'(state), 32'd0);
    rst = 1'b0; bus_util = 1'b0; m_reqs = '0;
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) m_reqs = '0;
      else if ($urandom_range(0, 7) == 0) m_reqs = N'($urandom);
      else if ($urandom_range(0, 1) == 0) m_reqs = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
      if ($urandom_range(0, 3) == 0) bus_util = ~bus_util;
      slaves = ($urandom_range(0, 7) == 0) ? NS'($urandom) : '0;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised bus arbiter for the shared serial bus, successor to the fixed 12-master bus controller. Arbitrates N_MASTERS request lines into a registered one-hot grant, selectable between fixed-priority and round-robin. Adds grant-acceptance and bus-hold watchdogs so a dead or stuck master cannot lock the bus. Sits between the master `b_request`/`b_grant` pins and the pulldown `bus_util`/slave-busy lines.

## Interface
- N_MASTERS, 12, number of request/grant channels (2..16)
- N_SLAVES, 6, width of slave-busy vector
- MID_W, 4, width of `mid_current`; must satisfy 2^MID_W >= N_MASTERS
- ACK_TIMEOUT, 15, max cycles in GRANT waiting for `bus_util` high (4-bit counter)
- HOLD_TIMEOUT, 1023, max cycles in BUSY before forced revoke (10-bit counter)

One clock; reset is synchronous and active-high.
- clk  in  1  bus clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- m_reqs  in  N_MASTERS  request lines, bit i = master i
- slaves  in  N_SLAVES  slave-busy lines, OR-reduced internally
- bus_util  in  1  bus-utilising line driven by the granted master
- rr_mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- m_grants  out  N_MASTERS  registered one-hot grant, zero when idle
- mid_current  out  MID_W  index of granted master, last owner retained when idle
- state  out  3  FSM state encoding for debug/display
- timeout_evt  out  1  one-cycle pulse on any watchdog revoke

## Operation
- States: IDLE=0, GRANT=1, BUSY=2, RELEASE=3.
- IDLE: if `m_reqs` != 0, select winner w, register `m_grants` = 1<<w, `mid_current` = w, go GRANT. Else stay, grants 0.
- Fixed mode: w = lowest set index. RR mode: w = first set index scanning upward from ptr+1, wrapping at N_MASTERS-1 → 0. ptr updates to w on every grant, in both modes.
- `rr_mode` is sampled only in IDLE; changes mid-transaction have no effect until next arbitration.
- GRANT: ack counter counts cycles. `bus_util` high → BUSY, counter clears. `m_reqs[w]` low with `bus_util` low → RELEASE (abandoned request). Counter reaches ACK_TIMEOUT with `bus_util` still low → RELEASE, pulse `timeout_evt`.
- BUSY: hold counter counts. `bus_util` low and all `slaves` low → RELEASE. `bus_util` low but any slave busy → stay BUSY (slave still completing). Hold counter reaches HOLD_TIMEOUT → RELEASE, pulse `timeout_evt`.
- RELEASE: `m_grants` = 0 for exactly one cycle, counters clear, go IDLE. This guarantees at least one dead cycle between owners.
- Requests from non-granted masters are ignored outside IDLE; there is no pre-emption.
- Reset values: `m_grants` = 0, `mid_current` = 0, `state` = IDLE, `timeout_evt` = 0, counters 0, ptr = N_MASTERS-1 (first RR search starts at master 0).
- Reset asserted in any state returns to IDLE at the next edge with grants dropped, regardless of `bus_util`.

## Timing
- Arbitration latency: request seen high at IDLE edge t → grant high after edge t, visible in cycle t+1.
- Grant stays high from GRANT entry through the last BUSY cycle. It drops on the RELEASE entry edge.
- Minimum handover: owner's `bus_util` falls at cycle k → RELEASE k+1 → IDLE k+2 → next grant visible k+3.
- ACK watchdog: grant issued at t with no `bus_util` → `timeout_evt` high in cycle t+ACK_TIMEOUT+1 and grants 0 in that same cycle.
- `timeout_evt` is registered and never high for more than one consecutive cycle.
- `state` and `mid_current` update on the same edge as `m_grants`.

## Test plan
- Reset: hold `rst` for 2 cycles with `m_reqs`=0xFFF → all outputs at reset values; the first grant after release goes to master 0 (`m_grants`=0x001).
- Fixed priority: `rr_mode`=0, `m_reqs`=0x034 held, each owner pulses `bus_util` for 3 cycles → grants 0x004 repeatedly; masters 4 and 5 starve.
- Round-robin: `rr_mode`=1, same stimulus → grant sequence 0x004, 0x010, 0x020, 0x004; handover gap is exactly 3 cycles after each `bus_util` fall.
- ACK timeout: `m_reqs`=0x020, `bus_util` never rises → `timeout_evt` pulse 16 cycles after grant, `mid_current`=5, then one RELEASE cycle and a re-grant to master 5.
- Slave extension and hold timeout: `bus_util` falls while `slaves`=0x08 → stays BUSY until `slaves`=0. Separately, `bus_util` stuck high → forced RELEASE after 1023 BUSY cycles with `timeout_evt` pulse.
- Reset mid-BUSY: assert `rst` while master 4 is in BUSY → `m_grants`=0 and `state`=0 next cycle.
